// File: rtl/ysyx_25020042_fetch_ctrl.sv
// ysyx_25020042_fetch_ctrl: single-outstanding instruction fetch sequencer with branch/trap redirect
module ysyx_25020042_fetch_ctrl #(
    parameter int PC_LEN = 32,
    parameter int INS_BYTES = 4,
    parameter logic [PC_LEN-1:0] RESET_PC = PC_LEN'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redir_valid,
    input  logic [PC_LEN-1:0] redir_pc,
    input  logic              trap_valid,
    input  logic [PC_LEN-1:0] trap_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_LEN-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              imem_resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [PC_LEN-1:0] inst_pc,
    output logic              inst_fault,
    output logic [PC_LEN-1:0] pc
);
    typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;
    state_t state, state_nxt;
    logic [PC_LEN-1:0] pc_nxt, target;
    logic redirect, req_fire, latch;
    assign redirect = trap_valid | redir_valid;
    assign target = trap_valid ? trap_pc : redir_pc;
    assign imem_req_valid = (state == REQ) && !rst;
    assign imem_req_addr = pc;
    assign inst_valid = (state == HOLD);
    assign req_fire = imem_req_valid && imem_req_ready;
    always_comb begin
        state_nxt = state;
        pc_nxt = redirect ? target : pc;
        latch = 1'b0;
        case (state)
            REQ: state_nxt = req_fire ? (redirect ? DROP : WAIT) : REQ;
            WAIT: begin
                latch = imem_resp_valid && !redirect;
                state_nxt = imem_resp_valid ? (redirect ? REQ : HOLD) : (redirect ? DROP : WAIT);
            end
            DROP: state_nxt = imem_resp_valid ? REQ : DROP;
            HOLD: begin
                pc_nxt = redirect ? target : (inst_ready ? pc + PC_LEN'(INS_BYTES) : pc);
                state_nxt = (inst_ready || redirect) ? REQ : HOLD;
            end
            default: state_nxt = REQ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc <= RESET_PC;
            inst <= '0;
            inst_pc <= '0;
            inst_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            if (latch) begin
                inst <= imem_resp_data;
                inst_pc <= pc;
                inst_fault <= imem_resp_err;
            end
        end
    end
endmodule
